// File: rtl/run_sequencer.sv
// Run controller for one or more cores. It steps them through reset, start, run and done.
// It also provides a watchdog, sticky per-core done flags and a RUN-cycle counter.
// Optional: define RUN_SEQ_PERF_EN to add done_cycle_o, which holds the cycle at which each
// core first reported done.
module run_sequencer #(
  parameter int unsigned NUM_CORES    = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned START_CYCLES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       go_i,
  input  logic                       clear_i,
  output logic                       core_reset_o,
  output logic [NUM_CORES-1:0]       core_start_o,
  input  logic [NUM_CORES-1:0]       core_done_i,
  output logic                       busy_o,
  output logic                       finished_o,
  output logic                       timeout_o,
  output logic [NUM_CORES-1:0]       done_mask_o,
  output logic [CNT_W-1:0]           cycles_o
`ifdef RUN_SEQ_PERF_EN
  ,
  output logic [NUM_CORES*CNT_W-1:0] done_cycle_o
`endif
);

  localparam int unsigned PhMax = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  typedef enum logic [2:0] {StIdle, StReset, StStart, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [PhW-1:0]       ph_q, ph_d;
  logic                 core_reset_q, core_reset_d;
  logic                 core_start_q, core_start_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic [NUM_CORES-1:0] merged;
`ifdef RUN_SEQ_PERF_EN
  logic [NUM_CORES*CNT_W-1:0] dc_q, dc_d;
`endif

  // Next state, run bookkeeping and the registered output values.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    finished_d = finished_q;
    timeout_d  = timeout_q;
    mask_d     = mask_q;
    cycles_d   = cycles_q;
`ifdef RUN_SEQ_PERF_EN
    dc_d       = dc_q;
`endif
    merged     = mask_q | core_done_i;

    if (clear_i) begin
      // An abort or acknowledge returns the block to a clean idle state.
      state_d    = StIdle;
      ph_d       = '0;
      finished_d = 1'b0;
      timeout_d  = 1'b0;
      mask_d     = '0;
      cycles_d   = '0;
`ifdef RUN_SEQ_PERF_EN
      dc_d       = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go_i) begin
            state_d    = StReset;
            ph_d       = '0;
            finished_d = 1'b0;
            timeout_d  = 1'b0;
            mask_d     = '0;
            cycles_d   = '0;
`ifdef RUN_SEQ_PERF_EN
            dc_d       = '0;
`endif
          end
        end
        // The go-accept cycle plus RST_CYCLES more. The cores see start one cycle after the
        // last reset edge.
        StReset: begin
          if (ph_q == PhW'(RST_CYCLES)) begin
            state_d = StStart;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + PhW'(1);
          end
        end
        StStart: begin
          if (ph_q == PhW'(START_CYCLES - 1)) begin
            state_d = StRun;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + PhW'(1);
          end
        end
        StRun: begin
          mask_d = merged;
`ifdef RUN_SEQ_PERF_EN
          for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (core_done_i[i] && !mask_q[i]) dc_d[i*CNT_W +: CNT_W] = cycles_q;
          end
`endif
          // Completion has priority over the watchdog in the same cycle.
          if (&merged) begin
            state_d    = StDone;
            finished_d = 1'b1;
          end else if (cycles_q == CNT_W'(MAX_CYCLES)) begin
            state_d   = StDone;
            timeout_d = 1'b1;
          end else begin
            cycles_d = cycles_q + CNT_W'(1);
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end

    core_reset_d = (state_d == StIdle) || (state_d == StReset);
    core_start_d = (state_d == StStart);
    busy_d       = (state_d == StReset) || (state_d == StStart) || (state_d == StRun);
  end

  // State and output registers. Reset is asynchronous.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      ph_q         <= '0;
      core_reset_q <= 1'b1;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      timeout_q    <= 1'b0;
      mask_q       <= '0;
      cycles_q     <= '0;
`ifdef RUN_SEQ_PERF_EN
      dc_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      core_reset_q <= core_reset_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
      timeout_q    <= timeout_d;
      mask_q       <= mask_d;
      cycles_q     <= cycles_d;
`ifdef RUN_SEQ_PERF_EN
      dc_q         <= dc_d;
`endif
    end
  end

  assign core_reset_o = core_reset_q;
  assign core_start_o = {NUM_CORES{core_start_q}};
  assign busy_o       = busy_q;
  assign finished_o   = finished_q;
  assign timeout_o    = timeout_q;
  assign done_mask_o  = mask_q;
  assign cycles_o     = cycles_q;
`ifdef RUN_SEQ_PERF_EN
  assign done_cycle_o = dc_q;
`endif

endmodule
